// File: rtl/ext_mem_pkg.sv
// rtl/ext_mem_pkg.sv - shared constants, op codes and counter widths for the external memory responder
package ext_mem_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int RD_CNT_W   = 16;
    localparam int WR_CNT_W   = 16;
    localparam int ERR_CNT_W  = 8;
    localparam int WAIT_CNT_W = 4;

    // Error counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// rtl/ext_mem_responder_if.sv - external memory port bundle between initiator and responder
interface ext_mem_responder_if;
    logic [15:0] ext_mem_addr;
    logic [31:0] ext_mem_wdata;
    logic        ext_mem_write;
    logic        ext_mem_read;
    logic [31:0] ext_mem_rdata;
    logic        ext_mem_ready;

    modport master (
        output ext_mem_addr, ext_mem_wdata, ext_mem_write, ext_mem_read,
        input  ext_mem_rdata, ext_mem_ready
    );

    modport slave (
        input  ext_mem_addr, ext_mem_wdata, ext_mem_write, ext_mem_read,
        output ext_mem_rdata, ext_mem_ready
    );
endinterface

// File: rtl/ext_mem_ram.sv
// rtl/ext_mem_ram.sv - single-port synchronous 32-bit data RAM with registered read
module ext_mem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Write-first is not needed: read returns the old word on a same-edge write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ext_mem_responder.sv
// rtl/ext_mem_responder.sv - wait-state memory responder with on-chip RAM and debug counters
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] OOR_RDATA   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    ext_mem_responder_if.slave   bus,
    output logic                 busy,
    output logic [RD_CNT_W-1:0]  rd_count,
    output logic [WR_CNT_W-1:0]  wr_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           wdata_q;
    op_e                   op_q;
    logic                  oor_q;
    logic                  err_q;

    logic                  req;
    op_e                   op_in;
    logic                  oor_in;
    logic                  err_in;

    logic [ADDR_W-1:0]     eff_addr;
    logic [31:0]           eff_wdata;
    op_e                   eff_op;
    logic                  eff_oor;

    logic                  ram_we;
    logic [31:0]           ram_rdata;

    assign req    = bus.ext_mem_read | bus.ext_mem_write;
    assign op_in  = bus.ext_mem_write ? OP_WR : OP_RD;
    assign oor_in = (bus.ext_mem_addr >> ADDR_W) != 16'd0;
    assign err_in = (bus.ext_mem_read & bus.ext_mem_write) | oor_in;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are pure state decode so reset clears them immediately.
    always_comb begin
        bus.ext_mem_ready = 1'b0;
        bus.ext_mem_rdata = 32'h0;
        busy              = (state != S_IDLE);
        if (state == S_RESP) begin
            bus.ext_mem_ready = 1'b1;
            if (op_q == OP_RD) begin
                bus.ext_mem_rdata = oor_q ? OOR_RDATA : ram_rdata;
            end
        end
    end

    // With zero wait states RESP is entered straight from IDLE, before the
    // request is latched, so the RAM is fed from the bus in IDLE.
    always_comb begin
        eff_addr  = addr_q;
        eff_wdata = wdata_q;
        eff_op    = op_q;
        eff_oor   = oor_q;
        if (state == S_IDLE) begin
            eff_addr  = bus.ext_mem_addr[ADDR_W-1:0];
            eff_wdata = bus.ext_mem_wdata;
            eff_op    = op_in;
            eff_oor   = oor_in;
        end
        ram_we = (state != S_RESP) && (state_nxt == S_RESP) &&
                 (eff_op == OP_WR) && !eff_oor;
    end

    // Request capture and wait-state countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            op_q     <= OP_RD;
            oor_q    <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                addr_q   <= bus.ext_mem_addr[ADDR_W-1:0];
                wdata_q  <= bus.ext_mem_wdata;
                op_q     <= op_in;
                oor_q    <= oor_in;
                err_q    <= err_in;
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Statistics advance on the edge that leaves RESP; one error per transaction at most.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (state == S_RESP) begin
            if (op_q == OP_WR) begin
                wr_count <= wr_count + 1'b1;
            end else begin
                rd_count <= rd_count + 1'b1;
            end
            if (err_q) begin
                err_count <= err_sat_inc(err_count);
            end
        end
    end

    ext_mem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (eff_addr),
        .wdata (eff_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb/tb_ext_mem_responder.sv - scoreboard bench for ext_mem_responder with zero and two wait states
module tb_ext_mem_responder;

    localparam logic [31:0] OOR0 = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ext_mem_responder_if ifc0 ();
    ext_mem_responder_if ifc2 ();

    logic        busy0, busy2;
    logic [15:0] rd0, wr0, rd2, wr2;
    logic [7:0]  err0, err2;

    ext_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .OOR_RDATA(OOR0)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0), .busy(busy0),
        .rd_count(rd0), .wr_count(wr0), .err_count(err0)
    );

    ext_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(ifc2), .busy(busy2),
        .rd_count(rd2), .wr_count(wr2), .err_count(err2)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, zero-wait-state responder.
    always @(negedge clk) begin
        exp_t e;
        if (ifc0.ext_mem_ready === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_ready: got ready=1 expected no transaction (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                check("dut0_latency", 32'(cyc - e.acc), 32'(e.lat));
                if (e.is_rd) check("dut0_rdata", ifc0.ext_mem_rdata, e.exp);
            end
        end else begin
            check("dut0_idle_rdata", ifc0.ext_mem_rdata, 32'h0);
        end
    end

    // Scoreboard monitor, two-wait-state responder.
    always @(negedge clk) begin
        exp_t e;
        if (ifc2.ext_mem_ready === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2_unexpected_ready: got ready=1 expected no transaction (cycle %0d)", cyc);
            end else begin
                e = q2.pop_front();
                check("dut2_latency", 32'(cyc - e.acc), 32'(e.lat));
                if (e.is_rd) check("dut2_rdata", ifc2.ext_mem_rdata, e.exp);
            end
        end else begin
            check("dut2_idle_rdata", ifc2.ext_mem_rdata, 32'h0);
        end
    end

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            ifc0.ext_mem_read  = rd;
            ifc0.ext_mem_write = wr;
            ifc0.ext_mem_addr  = a;
            ifc0.ext_mem_wdata = wd;
        end else begin
            ifc2.ext_mem_read  = rd;
            ifc2.ext_mem_write = wr;
            ifc2.ext_mem_addr  = a;
            ifc2.ext_mem_wdata = wd;
        end
    endtask

    task automatic xact(input int sel, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [31:0] wd, input logic [31:0] exp);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        drive(sel, rd, wr, a, wd);
        e.is_rd = rd & ~wr;
        e.exp   = exp;
        e.acc   = cyc + 1;
        e.lat   = (sel == 0) ? 0 : 2;
        if (sel == 0) q0.push_back(e);
        else          q2.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel == 0) ? ifc0.ext_mem_ready : ifc2.ext_mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, a, wd);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL xact_timeout: got no ready expected one (dut sel %0d addr %h)", sel, a);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(ifc0.ext_mem_ready), 32'd0);
        check("rst_ready2", 32'(ifc2.ext_mem_ready), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_rdata2", ifc2.ext_mem_rdata, 32'h0);
        check("rst_counts2", {rd2, wr2}, 32'h0);
        check("rst_err2", 32'(err2), 32'd0);
        rst = 1'b0;

        // Abort a read while it is waiting.
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 16'h0005, 32'h0);
        @(negedge clk);
        check("midwait_busy", 32'(busy2), 32'd1);
        rst = 1'b1;
        #1;
        check("midwait_rst_busy", 32'(busy2), 32'd0);
        check("midwait_rst_ready", 32'(ifc2.ext_mem_ready), 32'd0);
        drive(2, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midwait_idle_busy", 32'(busy2), 32'd0);
        check("midwait_counts", {rd2, wr2}, 32'h0);

        // Two wait states: write then read back.
        xact(2, 1'b0, 1'b1, 16'h0005, 32'hCAFE_F00D, 32'h0);
        xact(2, 1'b1, 1'b0, 16'h0005, 32'h0, 32'hCAFE_F00D);
        @(negedge clk);
        check("ws2_wr_count", 32'(wr2), 32'd1);
        check("ws2_rd_count", 32'(rd2), 32'd1);

        // Read and write together: write wins, one error.
        xact(2, 1'b1, 1'b1, 16'h0002, 32'hAAAA_5555, 32'h0);
        xact(2, 1'b1, 1'b0, 16'h0002, 32'h0, 32'hAAAA_5555);
        @(negedge clk);
        check("rw_err_count", 32'(err2), 32'd1);
        check("rw_wr_count", 32'(wr2), 32'd2);
        check("rw_rd_count", 32'(rd2), 32'd2);

        // Zero wait states: fill then back-to-back reads.
        for (int i = 0; i < 4; i++) xact(0, 1'b0, 1'b1, 16'(i), 32'h10 + 32'(i), 32'h0);
        for (int i = 0; i < 4; i++) xact(0, 1'b1, 1'b0, 16'(i), 32'h0, 32'h10 + 32'(i));
        @(negedge clk);
        check("ws0_rd_count", 32'(rd0), 32'd4);
        check("ws0_wr_count", 32'(wr0), 32'd4);

        // Out of range write dropped, read returns the fill value.
        xact(0, 1'b0, 1'b1, 16'h0100, 32'h0000_1234, 32'h0);
        xact(0, 1'b1, 1'b0, 16'h0100, 32'h0, OOR0);
        xact(0, 1'b1, 1'b0, 16'h0000, 32'h0, 32'h10);
        @(negedge clk);
        check("oor_err_count", 32'(err0), 32'd2);
        check("oor_wr_count", 32'(wr0), 32'd5);
        check("oor_rd_count", 32'(rd0), 32'd6);

        // Both ops and out of range: one error only, RAM untouched.
        xact(0, 1'b1, 1'b1, 16'h0203, 32'h0000_0005, 32'h0);
        xact(0, 1'b1, 1'b0, 16'h0003, 32'h0, 32'h13);
        @(negedge clk);
        check("rwoor_err_count", 32'(err0), 32'd3);
        check("rwoor_wr_count", 32'(wr0), 32'd6);

        // Error counter saturation.
        repeat (300) xact(0, 1'b1, 1'b0, 16'hFF00, 32'h0, OOR0);
        @(negedge clk);
        check("err_saturate", 32'(err0), 32'hFF);
        check("sat_rd_count", 32'(rd0), 32'd307);

        // Read counter wrap.
        @(negedge clk);
        force dut0.rd_count = 16'hFFFF;
        #1;
        release dut0.rd_count;
        xact(0, 1'b1, 1'b0, 16'h0001, 32'h0, 32'h11);
        @(negedge clk);
        check("rd_count_wrap", 32'(rd0), 32'd0);

        repeat (4) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
